// File: rtl/data_memory_access_ctrl_pkg.sv
// Shared definitions for the data memory load/store controller.
// Holds access-size codes, FSM encoding, the latched request layout and the alignment check.
package data_memory_access_ctrl_pkg;

  localparam int AW_DEF = 18;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [31:0] wdata;
  } req_t;

  // Illegal size, or a half/word access that is not naturally aligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = lo[0];
      SIZE_W:  bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_access_ctrl_align.sv
// Combinational lane logic: extracts and extends load data, and merges sub-word store data
// into the word read back from memory. Lanes are little-endian.
module data_memory_access_ctrl_align
  import data_memory_access_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shift_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    shift_s  = {lane_i, 3'b000};
    byte_s   = 8'(word_i >> shift_s);
    half_s   = lane_i[1] ? word_i[31:16] : word_i[15:0];
    load_o   = 32'h0000_0000;
    merged_o = word_i;
    case (size_i)
      SIZE_B: begin
        load_o   = {{24{signed_i & byte_s[7]}}, byte_s};
        merged_o = (word_i & ~(32'h0000_00FF << shift_s)) | ({24'h00_0000, wdata_i[7:0]} << shift_s);
      end
      SIZE_H: begin
        load_o   = {{16{signed_i & half_s[15]}}, half_s};
        merged_o = lane_i[1] ? {wdata_i[15:0], word_i[15:0]} : {word_i[31:16], wdata_i[15:0]};
      end
      SIZE_W: begin
        load_o   = word_i;
        merged_o = wdata_i;
      end
      default: begin
        load_o   = 32'h0000_0000;
        merged_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_access_ctrl.sv
// Load/store initiator between the MEM stage and a word-only data memory.
// Sub-word stores are done as read-modify-write; all outputs come straight from flops.
module data_memory_access_ctrl
  import data_memory_access_ctrl_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int AW     = AW_DEF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_write_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_signed_i,
  input  logic [31:0]   req_addr_i,
  input  logic [31:0]   req_wdata_i,
  output logic          resp_valid_o,
  output logic [31:0]   resp_rdata_o,
  output logic          resp_err_o,
  output logic [AW-1:0] mem_adress_o,
  output logic [31:0]   mem_write_data_o,
  output logic          mem_read_o,
  output logic          mem_write_o,
  input  logic [31:0]   mem_read_data_i
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic [AW-1:0]   mem_adress_q, mem_adress_d;
  logic [31:0]     mem_write_data_q, mem_write_data_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;
  logic            resp_valid_q, req_ready_q, mem_read_q, mem_write_q;
  logic            accept_s, bad_s;
  logic [31:0]     load_s, merged_s;
  logic            unused_addr_s;

  assign accept_s      = req_valid_i & req_ready_q;
  assign bad_s         = req_is_bad(req_size_i, req_addr_i[1:0]);
  // Address bits above the word range are dropped, so accesses wrap.
  assign unused_addr_s = ^req_addr_i[31:AW+2];

  data_memory_access_ctrl_align u_align (
    .size_i   (req_q.size),
    .signed_i (req_q.sgn),
    .lane_i   (req_q.lane),
    .word_i   (mem_read_data_i),
    .wdata_i  (req_q.wdata),
    .load_o   (load_s),
    .merged_o (merged_s)
  );

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    req_d            = req_q;
    mem_adress_d     = mem_adress_q;
    mem_write_data_d = mem_write_data_q;
    resp_rdata_d     = 32'h0000_0000;
    resp_err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          req_d = '{write: req_write_i, size: req_size_i, sgn: req_signed_i,
                    lane: req_addr_i[1:0], wdata: req_wdata_i};
          if (bad_s) begin
            state_d    = ST_RESP;
            resp_err_d = 1'b1;
          end else begin
            mem_adress_d = req_addr_i[AW+1:2];
            if (req_write_i && (req_size_i == SIZE_W)) begin
              state_d          = ST_WR;
              mem_write_data_d = req_wdata_i;
            end else begin
              state_d = ST_RD;
              cnt_d   = '0;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        // The read word is consumed on the last read cycle: merged for stores, aligned for loads.
        if (cnt_q == CW'(RD_LAT - 1)) begin
          if (req_q.write) begin
            state_d          = ST_WR;
            mem_write_data_d = merged_s;
          end else begin
            state_d      = ST_RESP;
            resp_rdata_d = load_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WR:   state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      req_q            <= '0;
      mem_adress_q     <= '0;
      mem_write_data_q <= 32'h0000_0000;
      resp_rdata_q     <= 32'h0000_0000;
      resp_err_q       <= 1'b0;
      resp_valid_q     <= 1'b0;
      req_ready_q      <= 1'b1;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      req_q            <= req_d;
      mem_adress_q     <= mem_adress_d;
      mem_write_data_q <= mem_write_data_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_err_q       <= resp_err_d;
      resp_valid_q     <= (state_d == ST_RESP);
      req_ready_q      <= (state_d == ST_IDLE);
      mem_read_q       <= (state_d == ST_RD);
      mem_write_q      <= (state_d == ST_WR);
    end
  end

  assign req_ready_o      = req_ready_q;
  assign resp_valid_o     = resp_valid_q;
  assign resp_rdata_o     = resp_rdata_q;
  assign resp_err_o       = resp_err_q;
  assign mem_adress_o     = mem_adress_q;
  assign mem_write_data_o = mem_write_data_q;
  assign mem_read_o       = mem_read_q;
  assign mem_write_o      = mem_write_q;

endmodule

// File: tb/tb_data_memory_access_ctrl.sv
// Bench for data_memory_access_ctrl with a behavioural word memory and a response scoreboard.
module tb_data_memory_access_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        preload = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [17:0] mem_adress;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:(1<<18)-1];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    logic [17:0] addr;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rd_seen = 0;
  int   wr_seen = 0;

  always #5 clk = ~clk;

  data_memory_access_ctrl dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_write_i      (req_write),
    .req_size_i       (req_size),
    .req_signed_i     (req_signed),
    .req_addr_i       (req_addr),
    .req_wdata_i      (req_wdata),
    .resp_valid_o     (resp_valid),
    .resp_rdata_o     (resp_rdata),
    .resp_err_o       (resp_err),
    .mem_adress_o     (mem_adress),
    .mem_write_data_o (mem_write_data),
    .mem_read_o       (mem_read),
    .mem_write_o      (mem_write),
    .mem_read_data_i  (mem_read_data)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 32'h0000_0000;
      mem[1] <= 32'hA1B2_C3D4;
    end else if (mem_write) begin
      mem[mem_adress] <= mem_write_data;
    end
  end

  assign mem_read_data = mem[mem_adress];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: checks every memory access and pops one expectation per response.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read || mem_write) begin
        check("rd_wr_exclusive", {31'h0, mem_read & mem_write}, 32'h0);
        if (sb_q.size() == 0) begin
          check("stray_mem_access", 32'h1, 32'h0);
        end else begin
          check("mem_adress", {14'h0, mem_adress}, {14'h0, sb_q[0].addr});
          if (mem_read) rd_seen++;
          if (mem_write) wr_seen++;
        end
      end
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("stray_resp", 32'h1, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
          check("latency_cycle", cyc, e.due);
          check("mem_read_cycles", rd_seen, e.nrd);
          check("mem_write_cycles", wr_seen, e.nwr);
          rd_seen = 0;
          wr_seen = 0;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee,
                       input int lat, input int nrd, input int nwr);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 32'h0, 32'h1);
      return;
    end
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{er, ee, cyc + lat - 1, a[19:2], nrd, nwr});
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("resp_timeout", 32'h0, 32'h1);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_read", {31'h0, mem_read}, 32'h0);
    check("rst_mem_write", {31'h0, mem_write}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_adress", {14'h0, mem_adress}, 32'h0);
    check("rst_mem_write_data", mem_write_data, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    reset   = 1'b0;
    preload = 1'b0;

    // Loads from word1 = A1B2C3D4.
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hA1B2_C3D4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h7, 32'h0, 32'hFFFF_FFA1, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 32'h0000_00A1, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h4, 32'h0, 32'hFFFF_C3D4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'h0000_A1B2, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, 32'hFFFF_FFD4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b00, 1'b0, 32'h6, 32'h0, 32'h0000_00B2, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'hFFFF_A1B2, 1'b0, 2, 1, 0);

    // Sub-word stores.
    issue(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_BEEF, 32'h0, 1'b0, 3, 1, 1);
    wait_idle();
    check("mem1_after_sh", mem[1], 32'hBEEF_C3D4);
    issue(1'b1, 2'b00, 1'b0, 32'h5, 32'h1234_5677, 32'h0, 1'b0, 3, 1, 1);
    wait_idle();
    check("mem1_after_sb", mem[1], 32'hBEEF_77D4);

    // Word store, then a sub-word store to the top lane.
    issue(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0, 2, 0, 1);
    wait_idle();
    check("mem0_after_sw", mem[0], 32'hFFFF_FFFF);
    issue(1'b1, 2'b00, 1'b0, 32'h3, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 1);
    wait_idle();
    check("mem0_after_sb3", mem[0], 32'hABFF_FFFF);

    // Upper address bits wrap onto word 2.
    issue(1'b1, 2'b10, 1'b0, 32'h0100_0008, 32'h1234_5678, 32'h0, 1'b0, 2, 0, 1);
    wait_idle();
    check("mem2_after_wrap_sw", mem[2], 32'h1234_5678);
    issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 32'h1234_5678, 1'b0, 2, 1, 0);

    // Errors: no memory traffic, one-cycle latency.
    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b0, 2'b01, 1'b1, 32'h5, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_1111, 32'h0, 1'b1, 1, 0, 0);
    issue(1'b1, 2'b11, 1'b0, 32'h4, 32'h2222_2222, 32'h0, 1'b1, 1, 0, 0);
    wait_idle();
    check("mem0_untouched_by_err", mem[0], 32'hABFF_FFFF);
    check("mem1_untouched_by_err", mem[1], 32'hBEEF_77D4);

    // Reset during the read cycle of a load drops it without a response.
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hBEEF_77D4, 1'b0, 2, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb_q.delete();
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (4) @(negedge clk);

    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'hBEEF_77D4, 1'b0, 2, 1, 0);
    issue(1'b0, 2'b00, 1'b1, 32'h3, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 1, 0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
